// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: div_state_t controller states, divide-by-zero quotient fill bit.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // The divide-by-zero quotient is all ones at any width; the top replicates this bit N times.
    localparam logic DBZ_QUOT_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the ALU slow path and the sequential divider.
// Latency: n/a (wires only).
// Backpressure: none; START is only honoured while the divider is IDLE or DONE.
//
// Signals: START, DIVIDEND, DIVISOR (requester -> divider);
//          BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO (divider -> requester).
// SIGNED (requester -> divider) exists only when SEQ_DIVIDER_SIGNED_EN is defined.
interface seq_divider_if #(
    parameter int N = 32
);
    logic         START;
    logic [N-1:0] DIVIDEND;
    logic [N-1:0] DIVISOR;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic         SIGNED;
`endif
    logic         BUSY;
    logic         DONE;
    logic [N-1:0] QUOTIENT;
    logic [N-1:0] REMAINDER;
    logic         DIV_BY_ZERO;

`ifdef SEQ_DIVIDER_SIGNED_EN
    modport master (
        output START, DIVIDEND, DIVISOR, SIGNED,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
    modport slave (
        input  START, DIVIDEND, DIVISOR, SIGNED,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
`else
    modport master (
        output START, DIVIDEND, DIVISOR,
        input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
    modport slave (
        input  START, DIVIDEND, DIVISOR,
        output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
    );
`endif

endinterface

// File: rtl/seq_divider_cla.sv
// Carry-lookahead adder/subtractor (parallel-prefix carries).
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: A, B (W bits) operands; ADD_SUB 0 = A+B, 1 = A-B;
//        SUM (W bits) result; COUT carry out (in subtract mode 1 means no borrow, A >= B).
module seq_divider_cla #(
    parameter int W = 33
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         ADD_SUB,
    output logic [W-1:0] SUM,
    output logic         COUT
);

    logic [W-1:0] b_eff;
    logic [W-1:0] p0;
    logic [W-1:0] g_pre;
    logic [W-1:0] p_pre;
    logic [W-1:0] g_nxt;
    logic [W-1:0] p_nxt;
    logic [W-1:0] carry;

    // Subtraction is A + ~B + 1; the +1 enters as the carry-in.
    assign b_eff = B ^ {W{ADD_SUB}};
    assign p0    = A ^ b_eff;

    // Kogge-Stone prefix: after the loop g_pre[i]/p_pre[i] cover bits i..0.
    always_comb begin
        g_pre = A & b_eff;
        p_pre = p0;
        g_nxt = '0;
        p_nxt = '0;
        for (int d = 1; d < W; d = d * 2) begin
            g_nxt = g_pre;
            p_nxt = p_pre;
            for (int i = d; i < W; i++) begin
                g_nxt[i] = g_pre[i] | (p_pre[i] & g_pre[i-d]);
                p_nxt[i] = p_pre[i] & p_pre[i-d];
            end
            g_pre = g_nxt;
            p_pre = p_nxt;
        end
    end

    assign carry = {g_pre[W-2:0] | (p_pre[W-2:0] & {(W-1){ADD_SUB}}), ADD_SUB};
    assign SUM   = p0 ^ carry;
    assign COUT  = g_pre[W-1] | (p_pre[W-1] & ADD_SUB);

endmodule

// File: rtl/seq_divider.sv
// Restoring integer divider, one quotient bit per clock (DIV/REM slow path beside the ALU).
// Latency: N+1 cycles from accepted START to DONE (1 cycle for divide by zero); II = N+1.
// Backpressure: BUSY high while iterating; START is ignored then and operands are not re-captured.
//
// Ports: CLK, RST (synchronous, active high); bus (seq_divider_if.slave) carries
//        START/DIVIDEND/DIVISOR in and BUSY/DONE/QUOTIENT/REMAINDER/DIV_BY_ZERO out.
// Optional: define SEQ_DIVIDER_SIGNED_EN to add bus.SIGNED (two's complement operands).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          CLK,
    input  logic          RST,
    seq_divider_if.slave  bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    div_state_t       state_q, state_d;
    logic [N-1:0]     d_q, d_d;       // divisor (magnitude)
    logic [N-1:0]     q_q, q_d;       // dividend shifting out, quotient shifting in
    logic [N:0]       rm_q, rm_d;     // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [N:0]       shifted;
    logic [N:0]       trial;
    logic             no_borrow;
    logic [N-1:0]     q_step;
    logic [N:0]       rm_step;
    logic [N-1:0]     quot_fix;
    logic [N-1:0]     rem_fix;
    logic [N-1:0]     dvd_mag;
    logic [N-1:0]     dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             negq_q, negq_d;  // quotient must be negated on exit
    logic             negr_q, negr_d;  // remainder follows dividend sign
`endif

    assign shifted = {rm_q[N-1:0], q_q[N-1]};

    seq_divider_cla #(
        .W (N + 1)
    ) u_cla (
        .A       (shifted),
        .B       ({1'b0, d_q}),
        .ADD_SUB (1'b1),
        .SUM     (trial),
        .COUT    (no_borrow)
    );

    assign q_step  = {q_q[N-2:0], no_borrow};
    assign rm_step = no_borrow ? trial : shifted;

`ifdef SEQ_DIVIDER_SIGNED_EN
    // The core only sees magnitudes; MIN maps to itself, which is its correct unsigned magnitude.
    assign dvd_mag  = (bus.SIGNED && bus.DIVIDEND[N-1]) ? -bus.DIVIDEND : bus.DIVIDEND;
    assign dvs_mag  = (bus.SIGNED && bus.DIVISOR[N-1])  ? -bus.DIVISOR  : bus.DIVISOR;
    assign quot_fix = negq_q ? -q_step : q_step;
    assign rem_fix  = negr_q ? -rm_step[N-1:0] : rm_step[N-1:0];
`else
    assign dvd_mag  = bus.DIVIDEND;
    assign dvs_mag  = bus.DIVISOR;
    assign quot_fix = q_step;
    assign rem_fix  = rm_step[N-1:0];
`endif

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        q_d     = q_q;
        rm_d    = rm_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            RUN: begin
                q_d   = q_step;
                rm_d  = rm_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    quot_d  = quot_fix;
                    rem_d   = rem_fix;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.START) begin
                    d_d   = dvs_mag;
                    q_d   = dvd_mag;
                    rm_d  = '0;
                    cnt_d = '0;
                    dbz_d = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    negq_d = bus.SIGNED & (bus.DIVIDEND[N-1] ^ bus.DIVISOR[N-1]);
                    negr_d = bus.SIGNED & bus.DIVIDEND[N-1];
`endif
                    if (bus.DIVISOR == '0) begin
                        // No iterations needed: results are fixed and raw dividend is returned.
                        state_d = DONE;
                        quot_d  = {N{DBZ_QUOT_FILL}};
                        rem_d   = bus.DIVIDEND;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            d_q     <= '0;
            q_q     <= '0;
            rm_q    <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            q_q     <= q_d;
            rm_q    <= rm_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign bus.BUSY        = (state_q == RUN);
    assign bus.DONE        = (state_q == DONE);
    assign bus.QUOTIENT    = quot_q;
    assign bus.REMAINDER   = rem_q;
    assign bus.DIV_BY_ZERO = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on DONE.
// Latency: checks BUSY count and DONE arrival for every operation.
// Backpressure: exercises START during RUN, back-to-back START in DONE, reset mid-operation.
module tb_seq_divider;

    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
    } exp_t;

    logic clk;
    logic rst;

    seq_divider_if #(.N(N)) bus ();

    seq_divider #(.N(N)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t         exp_q[$];
    int           total = 0;
    int           bad   = 0;
    logic [N-1:0] last_q = '0;
    logic [N-1:0] hold_q = '0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: plain arithmetic on the operands, truncating division for signed mode.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg);
        exp_t         e;
        logic [N-1:0] minv;
        minv = {1'b1, {(N-1){1'b0}}};
        e.dbz = 1'b0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (sg) begin
            if (a == minv && b == '1) begin
                e.q = minv;
                e.r = '0;
            end else begin
                e.q = $signed(a) / $signed(b);
                e.r = $signed(a) % $signed(b);
            end
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.DONE) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DONE with empty queue, want none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", bus.QUOTIENT, e.q);
                check("remainder", bus.REMAINDER, e.r);
                check("div_by_zero", N'(bus.DIV_BY_ZERO), N'(e.dbz));
            end
        end
    end

    // Called at a negedge; the request is presented across the following posedge.
    task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg,
                               input bit accepted);
        bus.START    = 1'b1;
        bus.DIVIDEND = a;
        bus.DIVISOR  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.SIGNED   = sg;
`endif
        if (accepted) begin
            exp_t e;
            e = model(a, b, sg);
`ifndef SEQ_DIVIDER_SIGNED_EN
            if (sg) e = model(a, b, 1'b0);
`endif
            exp_q.push_back(e);
            hold_q = last_q;
            last_q = e.q;
        end
    endtask

    // Walks negedges until DONE; inject_at >= 0 pulses a 9/3 START that must be ignored.
    task automatic wait_done(input int exp_busy, input int inject_at, input string name);
        int  busy_n;
        int  cyc;
        bit  seen;
        busy_n = 0;
        cyc    = 0;
        seen   = 1'b0;
        while (!seen && cyc < N + 10) begin
            @(negedge clk);
            cyc++;
            bus.START = 1'b0;
            if (cyc - 1 == inject_at) begin
                bus.START    = 1'b1;
                bus.DIVIDEND = 32'd9;
                bus.DIVISOR  = 32'd3;
            end
            if (bus.DONE) begin
                seen = 1'b1;
            end else if (bus.BUSY) begin
                busy_n++;
                if (busy_n == 1) check({name, "_held_quot"}, bus.QUOTIENT, hold_q);
            end
        end
        check({name, "_done_seen"}, N'(seen), N'(1));
        check({name, "_busy_cycles"}, N'(busy_n), N'(exp_busy));
        check({name, "_latency"}, N'(cyc), N'(exp_busy + 1));
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit sg,
                          input string name);
        drive_start(a, b, sg, 1'b1);
        wait_done((b == '0) ? 0 : N, -1, name);
    endtask

    initial begin
        int           done_n;
        logic [N-1:0] a;
        logic [N-1:0] b;
        bit           sg;

        rst          = 1'b1;
        bus.START    = 1'b0;
        bus.DIVIDEND = '0;
        bus.DIVISOR  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        bus.SIGNED   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", N'(bus.BUSY), '0);
        check("rst_done", N'(bus.DONE), '0);
        check("rst_quot", bus.QUOTIENT, '0);
        check("rst_rem", bus.REMAINDER, '0);
        check("rst_dbz", N'(bus.DIV_BY_ZERO), '0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, "basic");
        run_op(32'd5, 32'd0, 1'b0, "dbz");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "max_by_one");
        run_op(32'd3, 32'hFFFF_FFFF, 1'b0, "small_by_max");
        @(negedge clk);

        // START during RUN must not disturb the 100/7 operation.
        drive_start(32'd100, 32'd7, 1'b0, 1'b1);
        wait_done(N, 5, "ignore_start");

        // Back-to-back: new START presented in the DONE cycle.
        drive_start(32'd1000, 32'd10, 1'b0, 1'b1);
        wait_done(N, -1, "b2b_first");
        drive_start(32'd77, 32'd5, 1'b0, 1'b1);
        wait_done(N, -1, "b2b_second");
        @(negedge clk);

        // Reset in the middle of 100/7: no DONE, everything cleared.
        drive_start(32'd100, 32'd7, 1'b0, 1'b0);
        repeat (11) begin
            @(negedge clk);
            bus.START = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", N'(bus.BUSY), '0);
        check("midrst_done", N'(bus.DONE), '0);
        check("midrst_quot", bus.QUOTIENT, '0);
        check("midrst_rem", bus.REMAINDER, '0);
        check("midrst_dbz", N'(bus.DIV_BY_ZERO), '0);
        rst    = 1'b0;
        last_q = '0;
        done_n = 0;
        repeat (N + 5) begin
            @(negedge clk);
            if (bus.DONE) done_n++;
        end
        check("midrst_no_done", N'(done_n), '0);
        run_op(32'd50, 32'd5, 1'b0, "after_rst");

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "s_neg7_by2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s_7_byneg2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_byneg1");
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, "s_dbz");
`endif

        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 255);
                2:       b = '0;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom_range(1, 65535);
            endcase
            sg = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            sg = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(a, b, sg, "random");
        end

        repeat (3) @(negedge clk);
        check("queue_empty", N'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring integer divider: accepts DIVIDEND/DIVISOR, computes QUOTIENT/REMAINDER one bit per clock.
- Counterpart to the team's combinational CLA adder/subtractor. Each iteration's trial subtraction runs through the CLA in subtract mode.
- Sits beside the ALU as the slow-path DIV/REM unit, with a START/BUSY/DONE handshake.

Parameters:
- N, 32, operand/result width in bits (N >= 2).
- CNT_W, $clog2(N+1), iteration counter width (derived, not overridden).

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request pulse; sampled only when the block accepts (IDLE or DONE state).
- DIVIDEND  in  N  numerator; captured on the accepted START edge.
- DIVISOR  in  N  denominator; captured on the accepted START edge.
- BUSY  out  1  high while state = RUN.
- DONE  out  1  one-cycle pulse; results valid.
- QUOTIENT  out  N  result; held until the next accepted START.
- REMAINDER  out  N  result; held until the next accepted START.
- DIV_BY_ZERO  out  1  set with DONE when DIVISOR == 0; held with the results.

Behaviour:
- Reset: state IDLE. BUSY=0, DONE=0, QUOTIENT=0, REMAINDER=0, DIV_BY_ZERO=0, counter=0.
- RST wins over every other input. RST mid-RUN aborts the operation; no DONE is produced.
- States:
  - IDLE -> RUN: START=1 and DIVISOR != 0.
  - IDLE -> DONE: START=1 and DIVISOR == 0.
  - RUN -> DONE: after the N-th iteration (counter == N-1 at the edge).
  - DONE -> IDLE: default exit after one cycle.
  - DONE -> RUN or DONE: START=1 in the DONE cycle, giving back-to-back operation.
- START while in RUN is ignored; operands are not re-captured.
- Operand capture, accepted START edge t:
  - Latch divisor into D.
  - Quotient/shift register Q <= DIVIDEND.
  - Partial remainder Rm <= 0 (N+1 bits).
  - Counter <= 0.
  - DIV_BY_ZERO <= 0.
- RUN iteration, one per clock:
  - Shift: S = {Rm[N-1:0], Q[N-1]}.
  - Trial: T = S - {1'b0, D}, computed with an (N+1)-bit CLA instance, ADD_SUB=1.
  - If CLA COUT=1 (no borrow): Rm <= T, Q <= {Q[N-2:0], 1}.
  - Otherwise: Rm <= S, Q <= {Q[N-2:0], 0}.
  - Counter increments.
- Latency:
  - Nonzero divisor: START accepted at edge t, BUSY high for cycles t+1..t+N, DONE high in cycle t+N+1. Initiation interval is N+1.
  - Divide by zero: DONE high in cycle t+1, BUSY never asserted.
- Outputs update on the edge entering DONE:
  - QUOTIENT <= Q, REMAINDER <= Rm[N-1:0].
  - Divide by zero: QUOTIENT = all ones, REMAINDER = DIVIDEND, DIV_BY_ZERO = 1.
- Edge cases that need no special handling:
  - DIVIDEND < DIVISOR gives Q=0, R=DIVIDEND.
  - DIVISOR == 1 gives Q=DIVIDEND, R=0.
- QUOTIENT/REMAINDER do not change during RUN; they show the previous result.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined:
  - Adds input port SIGNED (1 bit), sampled with START.
  - SIGNED=1: operands are two's complement. The core divides the magnitudes; sign fix-up happens on the edge entering DONE, with no added latency.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case MIN / -1: QUOTIENT = MIN, REMAINDER = 0, no flag.
  - Divide by zero: QUOTIENT = all ones, REMAINDER = DIVIDEND (signed view).
- When undefined: no SIGNED port, unsigned only.

Decomposition:
- Package seq_divider_pkg holds:
  - State enum typedef, div_state_t {IDLE, RUN, DONE}.
  - Localparam for the divide-by-zero quotient (all ones).
- One sub-module: the existing CLA, instantiated with N+1 width and ADD_SUB tied to 1 for the trial subtraction.
- Sign fix-up (when enabled) stays inline; it is two conditional negations.

Test Plan:
- Basic: reset, then START with 100/7 (N=32) -> BUSY for 32 cycles; DONE in cycle t+33 with Q=14, R=2, DIV_BY_ZERO=0.
- Divide by zero: 5/0 -> DONE in cycle t+1, BUSY stays 0; Q=0xFFFFFFFF, R=5, DIV_BY_ZERO=1.
- Full range: 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, R=0. 3/0xFFFFFFFF -> Q=0, R=3.
- Handshake:
  - START pulsed mid-RUN with 9/3 -> ignored; the original 100/7 result is returned.
  - START asserted in the DONE cycle -> next operation starts with no IDLE cycle.
- Reset mid-op: RST at iteration 10 of 100/7 -> next cycle all outputs 0, state IDLE, no DONE. A following 50/5 gives Q=10, R=0.
- Signed (SEQ_DIVIDER_SIGNED_EN):
  - -7/2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF.
  - 7/-2 -> Q=0xFFFFFFFD, R=1.
  - 0x80000000/-1 -> Q=0x80000000, R=0.
